// File: rtl/sm_spi_sensor_pkg.sv
// Shared types and helpers for the round-robin SPI sensor reader.
package sm_spi_sensor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StStore
  } state_e;

  // Width of a channel index, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sm_spi_sensor_sck.sv
// SPI bit-timing generator: each bit is SCK_DIV clocks low then SCK_DIV clocks high.
// sample fires in the last low cycle (with the sck rising edge), bit_done in the last high
// cycle. sck is registered and idles high.
module sm_spi_sensor_sck #(
  parameter int unsigned SCK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,     // frame begins next cycle: drop sck together with cs
  input  logic en,        // currently shifting
  input  logic last,      // current bit is the final bit of the frame
  output logic sck,
  output logic sample,
  output logic bit_done
);

  localparam int unsigned CW = ($clog2(SCK_DIV) < 1) ? 1 : $clog2(SCK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;  // 0: low half, 1: high half
  logic          sck_q, sck_d;
  logic          cnt_end;

  assign cnt_end  = (cnt_q == CW'(SCK_DIV - 1));
  assign sample   = en & ~phase_q & cnt_end;
  assign bit_done = en & phase_q & cnt_end;
  assign sck      = sck_q;

  // Next-state for the half-period counter, phase and sck level.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    sck_d   = sck_q;
    if (start) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      sck_d   = 1'b0;
    end else if (en) begin
      if (cnt_end) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
        // After the last high phase sck stays high into STORE/IDLE.
        sck_d   = phase_q ? last : 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d   = '0;
      phase_d = 1'b0;
      sck_d   = 1'b1;
    end
  end

  // Timing registers; sck returns high asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sck_q   <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sck_q   <= sck_d;
    end
  end

endmodule

// File: rtl/sm_spi_sensor.sv
// Round-robin SPI sensor reader: polls CHANNELS read-only sensors, extracts
// frame[DATA_MSB:DATA_LSB] into one slot per channel and flags new samples.
// Optional macro SM_SPI_SENSOR_TRIGGER_EN adds a 'trig' input; frames then start only
// after a pending trigger instead of free-running.
module sm_spi_sensor
  import sm_spi_sensor_pkg::*;
#(
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned DATA_MSB    = 15,
  parameter int unsigned DATA_LSB    = 0,
  parameter int unsigned SCK_DIV     = 8,
  parameter int unsigned IDLE_CYCLES = 256
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic [CHANNELS-1:0]                cs,
  output logic                               sck,
  input  logic                               sdo,
  input  logic [idx_width(CHANNELS)-1:0]     rd_ch,
  output logic [31:0]                        rd_value,
  output logic [CHANNELS-1:0]                new_data,
  input  logic                               rd_ack,
`ifdef SM_SPI_SENSOR_TRIGGER_EN
  input  logic                               trig,
`endif
  output logic                               sample_valid,
  output logic [idx_width(CHANNELS)-1:0]     sample_ch
);

  localparam int unsigned CW = idx_width(CHANNELS);
  localparam int unsigned FW = DATA_MSB - DATA_LSB + 1;
  localparam int unsigned GW = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CHANNELS-1:0]   cs_q, cs_d;
  logic [CHANNELS-1:0]   new_data_q, new_data_d;
  logic [FW-1:0]         slot_q [CHANNELS];
  logic [FW-1:0]         field;

  logic gap_done, go, last_bit;
  logic sck_start, sck_en, sample, bit_done;

  assign gap_done = (gap_q == GW'(IDLE_CYCLES - 1));
  assign last_bit = (bit_q == BW'(FRAME_BITS - 1));
  // Shift rather than slice so every frame bit participates in the expression.
  assign field    = FW'(shift_q >> DATA_LSB);

`ifdef SM_SPI_SENSOR_TRIGGER_EN
  logic pend_q, pend_d;

  assign go = gap_done & (pend_q | trig);

  // Triggers collapse into one pending request, consumed on entry to SHIFT.
  always_comb begin
    pend_d = pend_q | trig;
    if (sck_start) begin
      pend_d = 1'b0;
    end
  end

  // Pending-trigger register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  assign go = gap_done;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (go) state_d = StShift;
      StShift: if (bit_done && last_bit) state_d = StStore;
      StStore: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and strobes.
  always_comb begin
    sck_start    = (state_q == StIdle) && go;
    sck_en       = (state_q == StShift);
    sample_valid = (state_q == StStore);
    sample_ch    = ch_q;
  end

  sm_spi_sensor_sck #(
    .SCK_DIV (SCK_DIV)
  ) u_sck (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sck_start),
    .en       (sck_en),
    .last     (last_bit),
    .sck      (sck),
    .sample   (sample),
    .bit_done (bit_done)
  );

  // Datapath next-state: gap and bit counters, shift register, channel, cs, flags.
  always_comb begin
    gap_d      = '0;
    bit_d      = bit_q;
    shift_d    = shift_q;
    ch_d       = ch_q;
    cs_d       = '1;
    new_data_d = new_data_q;

    if (state_q == StIdle && !gap_done) begin
      gap_d = gap_q + GW'(1);
    end else if (state_q == StIdle) begin
      gap_d = gap_q;
    end

    if (state_q != StShift) begin
      bit_d = '0;
    end else if (bit_done) begin
      bit_d = last_bit ? '0 : bit_q + BW'(1);
    end

    if (sample) begin
      shift_d = (shift_q << 1) | FRAME_BITS'(sdo);
    end

    if (state_d == StShift) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (ch_q == CW'(i)) cs_d[i] = 1'b0;
      end
    end

    if (rd_ack) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (rd_ch == CW'(i)) new_data_d[i] = 1'b0;
      end
    end

    // A store in the same cycle as an ack of that channel keeps the flag set.
    if (state_q == StStore) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (ch_q == CW'(i)) new_data_d[i] = 1'b1;
      end
      ch_d = (ch_q == CW'(CHANNELS - 1)) ? '0 : ch_q + CW'(1);
    end
  end

  // Datapath registers; cs returns high asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      ch_q       <= '0;
      cs_q       <= '1;
      new_data_q <= '0;
    end else begin
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      ch_q       <= ch_d;
      cs_q       <= cs_d;
      new_data_q <= new_data_d;
    end
  end

  // Result slots, written once per frame in STORE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) slot_q[i] <= '0;
    end else if (state_q == StStore) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (ch_q == CW'(i)) slot_q[i] <= field;
      end
    end
  end

  // Combinational read port; out-of-range channels read as zero.
  always_comb begin
    rd_value = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rd_ch == CW'(i)) rd_value = 32'(slot_q[i]);
    end
  end

  assign cs       = cs_q;
  assign new_data = new_data_q;

endmodule

// File: tb/tb_sm_spi_sensor.sv
// Directed bench for sm_spi_sensor: default config, 3 channels, 24-bit frame with field
// extraction, ack/store collision, mid-frame reset, and (with SM_SPI_SENSOR_TRIGGER_EN)
// triggered operation.
module tb_sm_spi_sensor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cs_index(input logic [2:0] c);
    case (c)
      3'b110:  return 0;
      3'b101:  return 1;
      3'b011:  return 2;
      default: return 7;
    endcase
  endfunction

  function automatic logic [15:0] frame_of(input int ch);
    case (ch)
      0:       return 16'h1111;
      1:       return 16'h2222;
      2:       return 16'h3333;
      default: return 16'h0000;
    endcase
  endfunction

  // d0: default parameters
  logic        rst0_n = 1'b0, sdo0 = 1'b0, rd_ack0 = 1'b0, sck0, sv0;
  logic [0:0]  cs0, new_data0, sch0, rd_ch0 = 1'b0;
  logic [31:0] rd_value0;

  // d1: three channels
  logic        rst1_n = 1'b0, sdo1 = 1'b0, rd_ack1 = 1'b0, sck1, sv1;
  logic [2:0]  cs1, new_data1;
  logic [1:0]  sch1, rd_ch1 = 2'd0;
  logic [31:0] rd_value1;
  logic [15:0] f1;
  assign f1 = frame_of(cs_index(cs1));

  // d2: 24-bit frame, field [19:8]
  logic        rst2_n = 1'b0, sdo2 = 1'b0, sck2, sv2;
  logic [0:0]  cs2, new_data2, sch2;
  logic [31:0] rd_value2;
  logic [23:0] fr2 = 24'hABCDEF;
  logic [15:0] fr0 = 16'hA5C3;

  sm_spi_sensor u_dut0 (
    .clk (clk), .rst_n (rst0_n), .cs (cs0), .sck (sck0), .sdo (sdo0), .rd_ch (rd_ch0),
    .rd_value (rd_value0), .new_data (new_data0), .rd_ack (rd_ack0),
`ifdef SM_SPI_SENSOR_TRIGGER_EN
    .trig (1'b1),
`endif
    .sample_valid (sv0), .sample_ch (sch0)
  );

  sm_spi_sensor #(
    .CHANNELS (3), .SCK_DIV (2), .IDLE_CYCLES (10)
  ) u_dut1 (
    .clk (clk), .rst_n (rst1_n), .cs (cs1), .sck (sck1), .sdo (sdo1), .rd_ch (rd_ch1),
    .rd_value (rd_value1), .new_data (new_data1), .rd_ack (rd_ack1),
`ifdef SM_SPI_SENSOR_TRIGGER_EN
    .trig (1'b1),
`endif
    .sample_valid (sv1), .sample_ch (sch1)
  );

  sm_spi_sensor #(
    .FRAME_BITS (24), .DATA_MSB (19), .DATA_LSB (8), .SCK_DIV (1), .IDLE_CYCLES (4)
  ) u_dut2 (
    .clk (clk), .rst_n (rst2_n), .cs (cs2), .sck (sck2), .sdo (sdo2), .rd_ch (1'b0),
    .rd_value (rd_value2), .new_data (new_data2), .rd_ack (1'b0),
`ifdef SM_SPI_SENSOR_TRIGGER_EN
    .trig (1'b1),
`endif
    .sample_valid (sv2), .sample_ch (sch2)
  );

  // Sensor models: shift the next frame bit out on each sck falling edge, MSB first.
  int   n0 = 0, n1 = 0, n2 = 0;
  logic psck0 = 1'b1, psck1 = 1'b1, psck2 = 1'b1;

  always @(negedge clk) begin
    if (cs0[0]) n0 <= 0;
    else if (!sck0 && psck0) begin sdo0 <= fr0[15-n0]; n0 <= n0 + 1; end
    psck0 <= sck0;
  end

  always @(negedge clk) begin
    if (cs1 == 3'b111) n1 <= 0;
    else if (!sck1 && psck1) begin sdo1 <= f1[15-n1]; n1 <= n1 + 1; end
    psck1 <= sck1;
  end

  always @(negedge clk) begin
    if (cs2[0]) n2 <= 0;
    else if (!sck2 && psck2) begin sdo2 <= fr2[23-n2]; n2 <= n2 + 1; end
    psck2 <= sck2;
  end

`ifdef SM_SPI_SENSOR_TRIGGER_EN
  logic       rst3_n = 1'b0, trig3 = 1'b0, sck3, sv3;
  logic [0:0] cs3, new_data3, sch3;
  logic [31:0] rd_value3;
  int         frames3 = 0;
  logic       pcs3 = 1'b1;

  sm_spi_sensor #(
    .SCK_DIV (1), .IDLE_CYCLES (4)
  ) u_dut3 (
    .clk (clk), .rst_n (rst3_n), .cs (cs3), .sck (sck3), .sdo (1'b0), .rd_ch (1'b0),
    .rd_value (rd_value3), .new_data (new_data3), .rd_ack (1'b0), .trig (trig3),
    .sample_valid (sv3), .sample_ch (sch3)
  );

  // Count cs falling edges of the triggered instance.
  always @(negedge clk) begin
    if (pcs3 && !cs3[0]) frames3 <= frames3 + 1;
    pcs3 <= cs3[0];
  end
`endif

  int         n;
  int         t1;
  int         cs_seq[$];
  int         sc_seq[$];
  logic [2:0] prev1;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("d0_rst_cs", 32'(cs0), 32'h1);
    check_eq("d0_rst_sck", 32'(sck0), 32'h1);
    check_eq("d0_rst_sv", 32'(sv0), 32'h0);
    check_eq("d0_rst_sch", 32'(sch0), 32'h0);
    check_eq("d0_rst_nd", 32'(new_data0), 32'h0);
    check_eq("d0_rst_rdv", rd_value0, 32'h0);

    // ---- d0: first frame timing and data ----
    @(negedge clk);
    rst0_n = 1'b1;
    n = 0;
    while (cs0[0] && n < 1000) begin
      @(posedge clk); #1; n++;
      if (n == 100) check_eq("d0_idle_sck", 32'(sck0), 32'h1);
    end
    check_eq("d0_first_cs_clock", n, 256);
    check_eq("d0_first_shift_sck", 32'(sck0), 32'h0);
    while (!sv0 && n < 2000) begin @(posedge clk); #1; n++; end
    check_eq("d0_sv_clock", n, 512);
    check_eq("d0_sv_cs_high", 32'(cs0), 32'h1);
    @(posedge clk); #1;
    check_eq("d0_sv_pulse", 32'(sv0), 32'h0);
    check_eq("d0_rd_value", rd_value0, 32'h0000A5C3);
    check_eq("d0_new_data", 32'(new_data0), 32'h1);
    rd_ch0 = 1'b1; #1;
    check_eq("d0_rd_oor", rd_value0, 32'h0);
    rd_ch0 = 1'b0;

    // ---- d0: reset in bit 7 of the second frame ----
    n = 0;
    while (cs0[0] && n < 600) begin @(posedge clk); #1; n++; end
    check_eq("d0_second_cs", n, 256);
    repeat (116) @(posedge clk);
    #1;
    check_eq("d0_mid_cs_low", 32'(cs0), 32'h0);
    rst0_n = 1'b0;
    #1;
    check_eq("d0_mrst_cs", 32'(cs0), 32'h1);
    check_eq("d0_mrst_sck", 32'(sck0), 32'h1);
    check_eq("d0_mrst_rdv", rd_value0, 32'h0);
    check_eq("d0_mrst_nd", 32'(new_data0), 32'h0);
    @(negedge clk);
    rst0_n = 1'b1;
    n = 0;
    while (cs0[0] && n < 1000) begin @(posedge clk); #1; n++; end
    check_eq("d0_post_rst_cs_clock", n, 256);
    rst0_n = 1'b0;

    // ---- d1: three channels round-robin ----
    @(negedge clk);
    rst1_n = 1'b1;
    prev1 = 3'b111;
    for (int c = 0; c < 400 && sc_seq.size() < 4; c++) begin
      @(posedge clk); #1;
      if (prev1 == 3'b111 && cs1 != 3'b111) cs_seq.push_back(cs_index(cs1));
      if (sv1) sc_seq.push_back(int'(sch1));
      prev1 = cs1;
    end
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("d1_cs_order%0d", i), (i < cs_seq.size()) ? cs_seq[i] : 99, i % 3);
      check_eq($sformatf("d1_sample_ch%0d", i), (i < sc_seq.size()) ? sc_seq[i] : 99, i % 3);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rd_ch1 = 2'(i); #1;
      check_eq($sformatf("d1_rd_ch%0d", i), rd_value1, (i < 3) ? 32'(frame_of(i)) : 32'h0);
    end
    check_eq("d1_new_data_all", 32'(new_data1), 32'h7);

    // Ack of channel 0 coincident with its STORE: set wins.
    rd_ch1 = 2'd0;
    n = 0;
    while (!(sv1 && sch1 == 2'd0) && n < 400) begin @(posedge clk); #1; n++; end
    check_eq("d1_store0_found", 32'(sv1 && sch1 == 2'd0), 32'h1);
    rd_ack1 = 1'b1;
    @(posedge clk); #1;
    rd_ack1 = 1'b0;
    check_eq("d1_ack_collide", 32'(new_data1), 32'h7);
    rd_ack1 = 1'b1;
    @(posedge clk); #1;
    rd_ack1 = 1'b0;
    check_eq("d1_ack_clear", 32'(new_data1), 32'h6);
    rst1_n = 1'b0;

    // ---- d2: 24-bit frame, field extraction and frame period ----
    @(negedge clk);
    rst2_n = 1'b1;
    n = 0;
    while (!sv2 && n < 300) begin @(posedge clk); #1; n++; end
    check_eq("d2_first_sv_clock", n, 4 + 48);
    t1 = n;
    @(posedge clk); #1; n++;
    check_eq("d2_rd_value", rd_value2, 32'h00000BCD);
    while (!sv2 && n < 600) begin @(posedge clk); #1; n++; end
    check_eq("d2_period", n - t1, 53);
    rst2_n = 1'b0;

`ifdef SM_SPI_SENSOR_TRIGGER_EN
    // ---- d3: triggered operation ----
    @(negedge clk);
    rst3_n = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("d3_no_trig_frames", frames3, 0);
    check_eq("d3_no_trig_cs", 32'(cs3), 32'h1);
    trig3 = 1'b1;
    @(negedge clk);
    trig3 = 1'b0;
    n = 0;
    while (cs3[0] && n < 50) begin @(negedge clk); n++; end
    check_eq("d3_trig_start", 32'(cs3), 32'h0);
    for (int k = 0; k < 3; k++) begin
      repeat (3) @(negedge clk);
      trig3 = 1'b1;
      @(negedge clk);
      trig3 = 1'b0;
    end
    repeat (300) @(negedge clk);
    check_eq("d3_frames", frames3, 2);
    check_eq("d3_idle_cs", 32'(cs3), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
